nibble_serial_adder: RTL
========================

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 16, operand/result width in bits; legal values are multiples of 4 and at least 4.
REQ-002 The block SHALL have a single clock; reset is synchronous and active-high.
REQ-003 The ports SHALL be, in order:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operands presented.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  result presented.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result bits.
- cout  output  1  carry-out of the MSB nibble.
- busy  output  1  operation in progress (state != IDLE).
REQ-004 The block SHALL instantiate exactly one CLA_4bit (ports a, b, cin, s, cout) as its only adder datapath.
REQ-005 The block SHALL feed the CLA_4bit from internal registers and consume the CLA_4bit outputs into internal registers.

Function
REQ-006 The state machine SHALL have three states: IDLE, RUN and DONE.
REQ-007 in_ready SHALL be 1 exactly when the state is IDLE; it is combinational from state only.
REQ-008 In IDLE, on a rising edge with in_valid=1, the block SHALL latch a, b and cin, clear the nibble index to 0, set the carry register to cin, and enter RUN.
REQ-009 In IDLE with in_valid=0, all registers SHALL hold.
REQ-010 In RUN, the CLA_4bit inputs SHALL be nibble[idx] of the latched A, nibble[idx] of the latched B, and the carry register.
REQ-011 Each RUN edge SHALL write the CLA s output into sum[4*idx+3:4*idx], load the carry register from the CLA cout, and increment idx.
REQ-012 When idx = WIDTH/4-1, the RUN edge SHALL also load the cout output from the CLA cout and transition to DONE.
REQ-013 Latency: out_valid SHALL rise exactly WIDTH/4 cycles after the accepting edge (4 cycles for WIDTH=16).
REQ-014 In DONE, out_valid SHALL be 1, and sum and cout SHALL be held stable until an edge with out_ready=1, which returns the block to IDLE.
REQ-015 out_valid SHALL be 0 in IDLE and RUN.
REQ-016 sum and cout SHALL be undefined to the consumer during RUN (partial values permitted); they SHALL retain the last result in IDLE until the next acceptance.
REQ-017 The result SHALL be (A + B + cin) mod 2^WIDTH in sum, and bit WIDTH of that full sum in cout.
REQ-018 Because in_ready=0 in DONE, an output handshake and a new input acceptance SHALL NOT occur on the same edge; the minimum issue interval is WIDTH/4+2 cycles when out_ready is held at 1.
REQ-019 in_valid, a, b and cin SHALL be ignored outside IDLE; latched operands are unaffected by input changes after acceptance.
REQ-020 idx SHALL be ceil(log2(WIDTH/4)) bits wide, minimum 1 bit, and SHALL never wrap during RUN.

Reset
REQ-021 On a clock edge with rst=1, the block SHALL enter IDLE and clear sum, cout, out_valid, the carry register, idx and the latched operands to 0.
REQ-022 After reset, in_ready SHALL be 1 and busy SHALL be 0.
REQ-023 rst SHALL override all other inputs in every state.
REQ-024 A reset asserted mid-RUN or in DONE SHALL abort the operation with no result ever presented for it.

Verification
REQ-025 Carry ripple: WIDTH=16, a=16'hFFFF, b=16'h0001, cin=0 accepted -> out_valid rises 4 cycles later with sum=16'h0000, cout=1.
REQ-026 Carry-in: a=16'h1234, b=16'h4321, cin=1 -> sum=16'h5556, cout=0.
REQ-027 Backpressure: a=16'h8000, b=16'h8000, out_ready held 0 for 3 cycles in DONE -> out_valid=1 and sum=16'h0000, cout=1 stable throughout; in_ready=0 throughout; IDLE one edge after out_ready=1.
REQ-028 Mid-operation reset: rst asserted 2 cycles into RUN -> next edge gives IDLE, out_valid=0, sum=0, cout=0, in_ready=1; no out_valid pulse follows.
REQ-029 Back-to-back operations plus a random check: in_valid and out_ready held at 1 for 10 random operand sets -> each result matches A+B+cin, and the accept-to-accept spacing is 6 cycles.
REQ-030 WIDTH=8: a=8'hF0, b=8'h10, cin=0 -> out_valid after 2 cycles with sum=8'h00, cout=1.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - nibble-serial adder built around a single 4-bit carry-lookahead adder
//
// CLA_4bit: 4-bit carry-lookahead adder.
//   a, b  : 4-bit operands
//   cin   : carry-in
//   s     : 4-bit sum
//   cout  : carry-out
//
// nibble_serial_adder: computes A + B + cin one nibble per cycle.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (in_ready only while idle)
//   a, b, cin           : operands, latched on acceptance
//   out_valid/out_ready : result handshake, result held until accepted
//   sum, cout           : result and carry-out of the MSB nibble
//   busy                : operation in progress

module CLA_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is expanded from g/p and cin directly so none ripples.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s    = p ^ c[3:0];
    assign cout = c[4];
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             out_valid_q, out_valid_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [3:0]       cla_a;
    logic [3:0]       cla_b;
    logic [3:0]       cla_s;
    logic             cla_cout;

    // Select the current nibble of each latched operand.
    always_comb begin
        cla_a = '0;
        cla_b = '0;
        for (int i = 0; i < NIB; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cla_a = a_q[4*i +: 4];
                cla_b = b_q[4*i +: 4];
            end
        end
    end

    CLA_4bit u_cla (
        .a    (cla_a),
        .b    (cla_b),
        .cin  (carry_q),
        .s    (cla_s),
        .cout (cla_cout)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        cout_d      = cout_q;
        out_valid_d = out_valid_q;
        idx_d       = idx_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < NIB; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        sum_d[4*i +: 4] = cla_s;
                    end
                end
                carry_d = cla_cout;
                if (idx_q == LAST_IDX) begin
                    // idx stays on the last nibble so it never wraps.
                    cout_d      = cla_cout;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
            idx_q       <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
            idx_q       <= idx_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
endmodule
